// File: rtl/chepai_digit_overlay_pkg.sv
// Shared definitions for the plate-digit overlay: segment indices, digit glyph ROM,
// debounce FSM encoding, default colours and the video pipeline payload.
package chepai_digit_overlay_pkg;

  // Segment bit positions inside a 7-bit glyph mask
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Digit code -> segment mask; codes 10..15 render blank
  localparam logic [15:0][6:0] SEG_ROM = {
    7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,  // 15..10
    7'h6F,                                     // 9 abcdfg
    7'h7F,                                     // 8 all
    7'h07,                                     // 7 abc
    7'h7D,                                     // 6 acdefg
    7'h6D,                                     // 5 acdfg
    7'h66,                                     // 4 bcfg
    7'h4F,                                     // 3 abcdg
    7'h5B,                                     // 2 abdeg
    7'h06,                                     // 1 bc
    7'h3F                                      // 0 abcdef
  };

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [23:0] DEF_FG_COLOR  = 24'hFF0000;
  localparam logic [23:0] DEF_BOX_COLOR = 24'h00FF00;

  // Everything that travels down the video pipeline alongside the pixel
  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic [23:0] data;
  } video_t;

endpackage

// File: rtl/chepai_digit_overlay_seg7_glyph_hit.sv
// Combinational 7-segment hit test: given the pixel offset inside the glyph box and
// the lit-segment mask, report whether the pixel lies on a lit segment.
module seg7_glyph_hit
  import chepai_digit_overlay_pkg::*;
#(
  parameter logic [11:0] SEG_LEN = 12'd24,
  parameter logic [11:0] SEG_TH  = 12'd4
) (
  input  logic [11:0] rx,
  input  logic [11:0] ry,
  input  logic [6:0]  seg_mask,
  output logic        hit
);

  localparam logic [11:0] GW = SEG_LEN + SEG_TH + SEG_TH;
  localparam logic [11:0] GH = SEG_LEN + SEG_LEN + SEG_TH + SEG_TH + SEG_TH;

  logic col_mid, col_left, col_right;
  logic row_top, row_mid, row_bot, row_upper, row_lower;
  logic [6:0] on_seg;

  // Decompose the glyph box into column/row bands, then combine per segment
  always_comb begin
    col_left  = (rx < SEG_TH);
    col_mid   = (rx >= SEG_TH) && (rx < SEG_TH + SEG_LEN);
    col_right = (rx >= SEG_TH + SEG_LEN) && (rx < GW);

    row_top   = (ry < SEG_TH);
    row_upper = (ry >= SEG_TH) && (ry < SEG_TH + SEG_LEN);
    row_mid   = (ry >= SEG_LEN + SEG_TH) && (ry < SEG_LEN + SEG_TH + SEG_TH);
    row_lower = (ry >= SEG_TH + SEG_TH + SEG_LEN) && (ry < GH - SEG_TH);
    row_bot   = (ry >= GH - SEG_TH) && (ry < GH);

    on_seg        = '0;
    on_seg[SEG_A] = row_top   && col_mid;
    on_seg[SEG_B] = row_upper && col_right;
    on_seg[SEG_C] = row_lower && col_right;
    on_seg[SEG_D] = row_bot   && col_mid;
    on_seg[SEG_E] = row_lower && col_left;
    on_seg[SEG_F] = row_upper && col_left;
    on_seg[SEG_G] = row_mid   && col_mid;

    hit = |(on_seg & seg_mask);
  end

endmodule

// File: rtl/chepai_digit_overlay.sv
// Plate-digit overlay: debounces the recognizer's digit code at frame ends and draws it
// as a 7-segment glyph plus the character-window outline on a 2-cycle video pipeline.
module chepai_digit_overlay
  import chepai_digit_overlay_pkg::*;
#(
  parameter logic [11:0] OV_X          = 12'd600,
  parameter logic [11:0] OV_Y          = 12'd40,
  parameter logic [11:0] SEG_LEN       = 12'd24,
  parameter logic [11:0] SEG_TH        = 12'd4,
  parameter logic [3:0]  STABLE_FRAMES = 4'd3,
  parameter logic [23:0] FG_COLOR      = DEF_FG_COLOR,
  parameter logic [23:0] BOX_COLOR     = DEF_BOX_COLOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_de,
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  input  logic [23:0] i_data,
  input  logic [3:0]  digit_in,
  input  logic [11:0] char_up,
  input  logic [11:0] char_down,
  input  logic [11:0] char_left,
  input  logic [11:0] char_right,
  output logic [23:0] o_data,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic [3:0]  shown_digit,
  output logic        shown_valid
);

  // Updated stable count at which the candidate is considered locked
  localparam logic [3:0] LOCK_CNT = STABLE_FRAMES - 4'd1;

  logic       vs_d1_q, vs_d1_d;
  logic       fe;
  logic       lock_hit;
  state_e     state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] stable_cnt_q, stable_cnt_d;
  logic [3:0] shown_digit_q, shown_digit_d;
  logic       shown_valid_q, shown_valid_d;

  logic [11:0] rx, ry;
  logic        in_org;
  logic [6:0]  seg_mask;
  logic        seg_hit;
  logic        box_ok, in_win, on_edge;

  video_t vid_p1_q, vid_p1_d;
  video_t vid_p2_q, vid_p2_d;
  logic   glyph_p1_q, glyph_p1_d;
  logic   box_p1_q, box_p1_d;

  // Frame-end detection and debounce of the digit code, sampled only at frame end
  always_comb begin
    vs_d1_d      = i_vs;
    fe           = vs_d1_q & ~i_vs;
    cand_d       = cand_q;
    stable_cnt_d = stable_cnt_q;
    if (fe) begin
      if (digit_in == cand_q) begin
        if (stable_cnt_q != 4'd15) begin
          stable_cnt_d = stable_cnt_q + 4'd1;
        end
      end else begin
        cand_d       = digit_in;
        stable_cnt_d = 4'd0;
      end
    end
    lock_hit = fe && (stable_cnt_d >= LOCK_CNT);
  end

  // Lock FSM: first lock enables rendering, later locks swap the digit at frame end only
  always_comb begin
    state_d       = state_q;
    shown_digit_d = shown_digit_q;
    shown_valid_d = shown_valid_q;
    case (state_q)
      SEARCH: begin
        if (lock_hit) begin
          shown_digit_d = cand_d;
          shown_valid_d = 1'b1;
          state_d       = LOCKED;
        end
      end
      LOCKED: begin
        if (lock_hit) begin
          shown_digit_d = cand_d;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Debounce and lock state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d1_q       <= 1'b0;
      state_q       <= SEARCH;
      cand_q        <= 4'd0;
      stable_cnt_q  <= 4'd0;
      shown_digit_q <= 4'd0;
      shown_valid_q <= 1'b0;
    end else begin
      vs_d1_q       <= vs_d1_d;
      state_q       <= state_d;
      cand_q        <= cand_d;
      stable_cnt_q  <= stable_cnt_d;
      shown_digit_q <= shown_digit_d;
      shown_valid_q <= shown_valid_d;
    end
  end

  // Stage 1: region hits for the glyph and window outline, capture of the pixel
  always_comb begin
    rx       = i_x - OV_X;
    ry       = i_y - OV_Y;
    in_org   = (i_x >= OV_X) && (i_y >= OV_Y);
    seg_mask = SEG_ROM[shown_digit_q];

    box_ok  = (char_left <= char_right) && (char_up <= char_down);
    in_win  = (i_x >= char_left) && (i_x <= char_right) &&
              (i_y >= char_up)   && (i_y <= char_down);
    on_edge = (i_x == char_left) || (i_x == char_right) ||
              (i_y == char_up)   || (i_y == char_down);

    glyph_p1_d = seg_hit && in_org && shown_valid_q && i_de;
    box_p1_d   = box_ok && in_win && on_edge && i_de;

    vid_p1_d.hs   = i_hs;
    vid_p1_d.vs   = i_vs;
    vid_p1_d.de   = i_de;
    vid_p1_d.x    = i_x;
    vid_p1_d.y    = i_y;
    vid_p1_d.data = i_data;
  end

  seg7_glyph_hit #(
    .SEG_LEN (SEG_LEN),
    .SEG_TH  (SEG_TH)
  ) u_glyph_hit (
    .rx       (rx),
    .ry       (ry),
    .seg_mask (seg_mask),
    .hit      (seg_hit)
  );

  // Stage 2: colour mux, glyph over outline over the incoming pixel
  always_comb begin
    vid_p2_d = vid_p1_q;
    if (glyph_p1_q) begin
      vid_p2_d.data = FG_COLOR;
    end else if (box_p1_q) begin
      vid_p2_d.data = BOX_COLOR;
    end
  end

  // Video pipeline registers; cleared on reset so outputs read zero immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_p1_q   <= '0;
      glyph_p1_q <= 1'b0;
      box_p1_q   <= 1'b0;
      vid_p2_q   <= '0;
    end else begin
      vid_p1_q   <= vid_p1_d;
      glyph_p1_q <= glyph_p1_d;
      box_p1_q   <= box_p1_d;
      vid_p2_q   <= vid_p2_d;
    end
  end

  assign o_data      = vid_p2_q.data;
  assign o_x         = vid_p2_q.x;
  assign o_y         = vid_p2_q.y;
  assign o_hs        = vid_p2_q.hs;
  assign o_vs        = vid_p2_q.vs;
  assign o_de        = vid_p2_q.de;
  assign shown_digit = shown_digit_q;
  assign shown_valid = shown_valid_q;

endmodule
